// File: rtl/vga_plot_engine.sv
// Buffers pixel plot commands in a small FIFO and streams them to a framebuffer write port.
// Optional macro VGA_PLOT_CLIP_EN: discard off-screen commands at accept time and count them.
module vga_plot_engine #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XRES       = 160,
  parameter int unsigned YRES       = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  input  logic [8:0]  cmd_colour,
  output logic        cmd_ready,
  output logic [14:0] fb_addr,
  output logic [8:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic [31:0] status
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e state_q, state_d;

  logic [15:0] mem_x [FIFO_DEPTH];
  logic [15:0] mem_y [FIFO_DEPTH];
  logic [8:0]  mem_c [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [14:0]     fb_addr_q, fb_addr_d;
  logic [8:0]      fb_data_q, fb_data_d;

  logic        full, empty, accept, in_range, push, pop;
  logic [15:0] head_x, head_y;
  logic [8:0]  head_c;
  logic [14:0] head_addr;
  logic [15:0] clip_cnt;

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  assign accept    = cmd_valid & cmd_ready;
  assign push      = accept & in_range;
  // IDLE pops whenever data is waiting; WRITE pops only as the current write retires.
  assign pop       = ~empty & ((state_q == StIdle) | fb_ready);

  assign head_x = mem_x[rd_ptr_q];
  assign head_y = mem_y[rd_ptr_q];
  assign head_c = mem_c[rd_ptr_q];
  // Arithmetic modulo 2^15 gives the same result as computing wide and truncating.
  assign head_addr = 15'(head_y) * 15'(XRES) + 15'(head_x);

`ifdef VGA_PLOT_CLIP_EN
  logic [15:0] clip_cnt_q;

  assign in_range = (cmd_x < 16'(XRES)) && (cmd_y < 16'(YRES));
  assign clip_cnt = clip_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_cnt_q <= '0;
    end else if (accept && !in_range && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end
`else
  assign in_range = 1'b1;
  assign clip_cnt = '0;
`endif

  always_comb begin
    state_d   = state_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d   = StWrite;
          fb_addr_d = head_addr;
          fb_data_d = head_c;
        end
      end
      StWrite: begin
        if (fb_ready) begin
          if (!empty) begin
            fb_addr_d = head_addr;
            fb_data_d = head_c;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr_q] <= cmd_x;
      mem_y[wr_ptr_q] <= cmd_y;
      mem_c[wr_ptr_q] <= cmd_colour;
    end
  end

  assign fb_we   = (state_q == StWrite);
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;
  assign status  = {clip_cnt, 8'h00, 4'(count_q), 2'b00, full, fb_we | ~empty};

endmodule

// File: doc/vga_plot_engine.md
VGA_PLOT_ENGINE -- requirements
Module: vga_plot_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, plot-command buffer depth (power of two, 2..8).
REQ-002 SHALL have parameter XRES, default 160, framebuffer width in pixels.
REQ-003 SHALL have parameter YRES, default 120, framebuffer height in pixels.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  plot request strobe from the CPU-side VGA write register.
REQ-007 SHALL have port cmd_x  input  16  pixel x coordinate.
REQ-008 SHALL have port cmd_y  input  16  pixel y coordinate.
REQ-009 SHALL have port cmd_colour  input  9  pixel colour.
REQ-010 SHALL have port cmd_ready  output  1  high when the command buffer is not full.
REQ-011 SHALL have port fb_addr  output  15  framebuffer word address.
REQ-012 SHALL have port fb_data  output  9  framebuffer write data.
REQ-013 SHALL have port fb_we  output  1  framebuffer write request.
REQ-014 SHALL have port fb_ready  input  1  framebuffer accepts the write in the cycle fb_we and fb_ready are both high.
REQ-015 SHALL have port status  output  32  CPU-readable status word.

Function
REQ-016 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are high, storing {x, y, colour} at the FIFO tail.
REQ-017 SHALL ignore cmd_valid while cmd_ready is low; no state change, no overwrite.
REQ-018 SHALL derive cmd_ready from the registered occupancy count only; a pop in the same cycle as full does not allow a push.
REQ-019 SHALL use a two-state output FSM: IDLE (fb_we=0) and WRITE (fb_we=1).
REQ-020 IDLE -> WRITE when the FIFO is non-empty: pop head, load fb_addr = y*XRES + x (truncated to 15 bits) and fb_data = colour.
REQ-021 In WRITE, fb_addr/fb_data/fb_we SHALL hold stable until fb_ready is sampled high.
REQ-022 WRITE with fb_ready=1: pop and reload next command and remain in WRITE if FIFO non-empty (one pixel per cycle sustained), else return to IDLE.
REQ-023 Latency: command accepted at edge k into an empty engine in IDLE SHALL present fb_we=1 after edge k+1.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 status[0] SHALL be busy = (state==WRITE) or FIFO non-empty; status[1] = full; status[7:4] = occupancy count; status[3:2] = 0.
REQ-027 status[31:16] SHALL report the clipped-command counter (see Configuration); status[15:8] = 0.

Reset
REQ-028 resetn low SHALL immediately force: state IDLE, FIFO empty, pointers 0, fb_we=0, fb_addr=0, fb_data=0, cmd_ready=1, status=0.
REQ-029 Reset during WRITE SHALL abandon the pending write and discard all buffered commands.

Configuration
REQ-030 Macro VGA_PLOT_CLIP_EN defined: commands with x>=XRES or y>=YRES SHALL be discarded at accept time (not stored), and a 16-bit counter in status[31:16] SHALL increment, saturating at 0xFFFF.
REQ-031 Macro VGA_PLOT_CLIP_EN undefined: all commands stored; address computed with truncation only; status[31:16] = 0.

Verification
REQ-032 Reset, then single cmd (x=5, y=2, colour=0x1FF), fb_ready=1 -> one fb_we pulse, fb_addr=325, fb_data=0x1FF, busy returns to 0.
REQ-033 fb_ready=0, push 5 cmds back-to-back (depth 4) -> 1 in output stage, 4 buffered, cmd_ready=0, 6th cmd dropped; release fb_ready -> 5 writes in push order on consecutive cycles.
REQ-034 fb_ready toggling every cycle with FIFO loaded -> fb_addr/fb_data never change while fb_we=1 and fb_ready=0.
REQ-035 With VGA_PLOT_CLIP_EN: cmd (x=160, y=0) -> no fb_we, status[31:16]=1; cmd (x=159, y=119) -> fb_addr=19199.
REQ-036 Assert resetn low mid-WRITE with 3 buffered cmds -> fb_we=0 asynchronously, status=0; after release no writes occur.
